// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder -- bit-serial-by-nibble adder.
//   Accepts one operand set (a, b, cin) on an in_valid/in_ready handshake,
//   then ripples one 4-bit slice per clock for WIDTH/4 clocks. The result
//   (sum, carry, ovf) is presented with out_valid and held until out_ready.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready operand handshake (in_ready only in IDLE)
//   a, b, cin      operands and carry-in, latched on acceptance
//   out_valid/ready result handshake (out_valid only in DONE)
//   sum, carry     a+b+cin modulo 2^WIDTH, carry out of MSB
//   ovf            signed overflow (carry into MSB ^ carry out of MSB)
//   busy           high while slices are being computed

// One 4-bit ripple slice; also exposes the carry into bit 3 so the top
// can form the signed-overflow flag on the most significant slice.
module nsa_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [3:0] lo;
  logic [4:0] full;

  assign lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
  assign full = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
  assign c3   = lo[3];
  assign s    = full[3:0];
  assign co   = full[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [NIB-1:0][3:0] a_r, b_r, sum_r;
  logic                creg;
  logic [KW-1:0]       k;
  logic [3:0]          s_nib;
  logic                c_out, c_msb;
  logic                last, accept;

  assign last   = (k == KW'(NIB - 1));
  assign accept = in_valid && (state == IDLE);

  nsa_slice u_slice (
    .a  (a_r[k]),
    .b  (b_r[k]),
    .ci (creg),
    .s  (s_nib),
    .co (c_out),
    .c3 (c_msb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: RUN never stalls; DONE waits only on out_ready
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Handshake / status outputs are pure functions of state, so in_ready
  // stays low in the DONE cycle regardless of out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. Operand registers need no reset: they are always loaded on
  // acceptance before being used.
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      creg  <= 1'b0;
      sum_r <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      creg  <= cin;
      k     <= '0;
      sum_r <= '0;
    end else if (state == RUN) begin
      sum_r[k] <= s_nib;
      creg     <= c_out;
      k        <= k + 1'b1;
      if (last) begin
        carry <= c_out;
        ovf   <= c_msb ^ c_out;
      end
    end
  end

  assign sum = sum_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        iv16, ir16, ci16, ov16, or16, c16, o16, bz16;
  logic [15:0] a16, b16, s16;
  // WIDTH=4 instance
  logic        iv4, ir4, ci4, ov4, or4, c4, o4, bz4;
  logic [3:0]  a4, b4, s4;

  int nvec = 0;
  int nerr = 0;

  nibble_serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .carry(c16),
    .ovf(o16), .busy(bz16)
  );

  nibble_serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .carry(c4),
    .ovf(o4), .busy(bz4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=16 operation. in_valid is left high with junk data during
  // RUN and DONE to show it is ignored there. hold = DONE cycles with
  // out_ready low before the consumer takes the result.
  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input int hold,
                      input logic es_c, input logic es_o, input logic [15:0] es);
    int lat;
    chk({tag, "/in_ready"}, 64'(ir16), 64'd1);
    a16 = ta; b16 = tb; ci16 = tc; iv16 = 1'b1; or16 = 1'b0;
    tick();
    chk({tag, "/busy"}, 64'({bz16, ir16}), 64'b10);
    a16 = ~ta; b16 = 16'h5a5a; ci16 = ~tc;
    lat = 0;
    while (!ov16 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'd4);
    chk({tag, "/result"}, 64'({c16, o16, s16}), 64'({es_c, es_o, es}));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "/hold"}, 64'({ov16, ir16, c16, o16, s16}), 64'({2'b10, es_c, es_o, es}));
      tick();
    end
    or16 = 1'b1;
    chk({tag, "/done_rdy"}, 64'(ir16), 64'd0);
    tick();
    iv16 = 1'b0; or16 = 1'b0;
    chk({tag, "/to_idle"}, 64'({ov16, ir16, bz16}), 64'b010);
  endtask

  // One WIDTH=4 operation with a randomly stalling consumer.
  task automatic op4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                     input logic tc, input logic es_c, input logic es_o, input logic [3:0] es);
    int  lat;
    bit  done;
    lat = 0;
    while (!ir4 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "/in_ready"}, 64'(ir4), 64'd1);
    a4 = ta; b4 = tb; ci4 = tc; iv4 = 1'b1; or4 = 1'b0;
    tick();
    iv4 = 1'b0; a4 = ~ta;
    lat = 0;
    while (!ov4 && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'd1);
    chk({tag, "/result"}, 64'({c4, o4, s4}), 64'({es_c, es_o, es}));
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      or4 = (i == 15) ? 1'b1 : 1'($urandom_range(0, 1));
      done = or4;
      tick();
      if (!done)
        chk({tag, "/stall"}, 64'({ov4, c4, o4, s4}), 64'({1'b1, es_c, es_o, es}));
    end
    or4 = 1'b0;
    chk({tag, "/released"}, 64'(ov4), 64'd0);
  endtask

  initial begin
    logic [4:0] full;
    logic       eo;
    rst = 1'b1;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
    iv4  = 1'b0; or4  = 1'b0; a4  = '0; b4  = '0; ci4  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset16", 64'({ir16, ov16, bz16, c16, o16, s16}), 64'({3'b100, 2'b00, 16'h0000}));
    chk("reset4",  64'({ir4, ov4, bz4, c4, o4, s4}),       64'({3'b100, 2'b00, 4'h0}));

    op16("ffff+1",      16'hFFFF, 16'h0001, 1'b0, 0, 1'b1, 1'b0, 16'h0000);
    op16("7fff+1",      16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b1, 16'h8000);
    op16("1234+4321+1", 16'h1234, 16'h4321, 1'b1, 0, 1'b0, 1'b0, 16'h5556);
    op16("hold3",       16'h8000, 16'h8000, 1'b0, 3, 1'b1, 1'b1, 16'h0000);

    // Reset after two RUN cycles, with in_valid asserted during the reset edge.
    a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    tick();
    tick();
    rst = 1'b1; iv16 = 1'b1; a16 = 16'h0003; b16 = 16'h0004; ci16 = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrun_rst", 64'({ir16, ov16, bz16, s16}), 64'({3'b100, 16'h0000}));
    op16("3+4", 16'h0003, 16'h0004, 1'b0, 0, 1'b0, 1'b0, 16'h0007);

    op4("f+f+1", 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 4'hF);

    // All 8 operand bits (a, b) with both carry-ins on WIDTH=4; overflow
    // from the sign rule.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ta, tb;
      logic       tc;
      ta = 4'(i);
      tb = 4'(i >> 4);
      tc = 1'(i >> 8);
      full = {1'b0, ta} + {1'b0, tb} + {4'b0000, tc};
      eo   = (ta[3] == tb[3]) && (full[3] != ta[3]);
      op4("sweep", ta, tb, tc, full[4], eo, full[3:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
